// File: rtl/pico_tx_controller_if.sv
// Byte stream feeding the PICO transmitter: valid/ready handshake plus an end-of-transaction flag.
interface pico_tx_controller_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/pico_tx_controller.sv
// PICO link transmitter: serialises stream bytes MSB first on sclk/serial_out, framing with idle gaps.
// Optional build macro PICO_TX_ADDR_CHECK_EN rejects a 0x00 address byte.
module pico_tx_controller #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                 iclk,
    input  logic                 rstn,
    pico_tx_controller_if.slave  tx,
    output logic                 sclk,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int unsigned     HcW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned     GapW    = $clog2(GAP_CYCLES + 1);
    localparam logic [HcW-1:0]  HcLast  = HcW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [GapW-1:0] GapEnd  = GapW'(GAP_CYCLES);

    typedef enum logic [1:0] {StIdle, StShift, StWait, StGap} state_e;

    state_e          state_q, state_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            last_q, last_d;
    logic [HcW-1:0]  half_q, half_d;
    logic [2:0]      bit_q, bit_d;
    logic [GapW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            rdy_en_q;
    logic            tx_ready_int;
    logic            accept;
    logic            load;

    // Held low for the first cycle after reset so tx_ready never depends on rstn directly.
    assign tx_ready_int = rdy_en_q & ((state_q == StIdle) | (state_q == StWait));
    assign tx.tx_ready  = tx_ready_int;
    assign accept       = tx.tx_valid & tx_ready_int;

    assign sclk       = sclk_q;
    assign serial_out = shreg_q[7];
    assign done       = done_q;
    assign err        = err_q;
    // The done cycle is still spent in StGap; an err cycle may already be back in StIdle.
    assign busy       = (state_q != StIdle) | err_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        half_d  = half_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef PICO_TX_ADDR_CHECK_EN
                    if (tx.tx_data == 8'h00) begin
                        err_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
`else
                    load = 1'b1;
`endif
                end
            end
            StShift: begin
                if (half_q != HcLast) begin
                    half_d = half_q + 1'b1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    half_d = '0;
                end else begin
                    sclk_d = 1'b0;
                    half_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        cnt_d = '0;
                        if (last_q) begin
                            state_d = StGap;
                            shreg_d = '0;
                        end else begin
                            // serial_out keeps bit 0 while waiting for the next byte
                            state_d = StWait;
                        end
                    end else begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            StWait: begin
                if (accept) begin
                    load = 1'b1;
                end else if (cnt_q == GapLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GapEnd) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GapLast) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d = StShift;
            shreg_d = tx.tx_data;
            last_d  = tx.tx_last;
            half_d  = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
        end
    end

    always_ff @(posedge iclk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            last_q   <= 1'b0;
            half_q   <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            sclk_q   <= sclk_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pico_tx_controller.sv
// Directed bench for pico_tx_controller: bit scoreboard on sclk rises plus a PICO receiver model.
module tb_pico_tx_controller;
    logic iclk = 1'b0;
    logic rstn = 1'b0;
    always #5 iclk = ~iclk;

    pico_tx_controller_if tif ();
    pico_tx_controller_if tif1 ();

    logic sclk, serial_out, busy, done, err;
    logic sclk1, sout1, busy1, done1, err1;

    pico_tx_controller #(.CLK_DIV(2), .GAP_CYCLES(16)) dut (
        .iclk(iclk), .rstn(rstn), .tx(tif), .sclk(sclk), .serial_out(serial_out),
        .busy(busy), .done(done), .err(err)
    );

    pico_tx_controller #(.CLK_DIV(1), .GAP_CYCLES(16)) dut1 (
        .iclk(iclk), .rstn(rstn), .tx(tif1), .sclk(sclk1), .serial_out(sout1),
        .busy(busy1), .done(done1), .err(err1)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned extra_rises = 0;
    logic        exp_bits[$];
    int unsigned rise_cycs[$];
    int unsigned done_cycs[$];
    int unsigned err_cycs[$];
    int unsigned busy_up[$];
    int unsigned busy_dn[$];
    logic [7:0]  rx_ptr = '0;
    logic [7:0]  rx_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned rel(input int unsigned q[$], input int unsigned i,
                                        input int unsigned base);
        return (i < q.size()) ? q[i] - base : 32'hDEAD;
    endfunction

    // Samples 1 time unit after each rising edge; also models the PICO receiver framing.
    task automatic monitor();
        logic        sclk_p = 1'b0;
        logic        busy_p = 1'b0;
        logic [7:0]  sh = '0;
        int unsigned nb = 0;
        int unsigned low_run = 0;
        bit          have_ptr = 1'b0;
        forever begin
            @(posedge iclk);
            cyc++;
            #1;
            if (sclk && !sclk_p) begin
                rise_cycs.push_back(cyc);
                if (exp_bits.size() == 0) extra_rises++;
                else check("bit", serial_out, exp_bits.pop_front());
                sh = {sh[6:0], serial_out};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (!have_ptr) begin
                        rx_ptr   = sh;
                        have_ptr = 1'b1;
                    end else begin
                        rx_wdata = sh;
                        rx_ptr   = rx_ptr + 8'd1;
                    end
                end
            end
            low_run = sclk ? 0 : low_run + 1;
            if (low_run == 8) begin
                nb       = 0;
                have_ptr = 1'b0;
            end
            if (done) done_cycs.push_back(cyc);
            if (err) err_cycs.push_back(cyc);
            if (busy && !busy_p) busy_up.push_back(cyc);
            if (!busy && busy_p) busy_dn.push_back(cyc);
            sclk_p = sclk;
            busy_p = busy;
        end
    endtask

    // Leaves tx_valid high; returns at the negedge of cycle 1 with acc = cycle 0 count.
    task automatic send(input logic [7:0] b, input logic l, input bit push,
                        output int unsigned acc);
        int unsigned k = 0;
        tif.tx_data  = b;
        tif.tx_last  = l;
        tif.tx_valid = 1'b1;
        while (!tif.tx_ready && k < 200) begin
            @(negedge iclk);
            k++;
        end
        check("ready_wait", tif.tx_ready, 1);
        acc = cyc;
        if (push) for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        @(negedge iclk);
    endtask

    task automatic wait_ev(input bit use_err, input int unsigned n0, input int unsigned bound);
        int unsigned k = 0;
        while (((use_err ? err_cycs.size() : done_cycs.size()) == n0) && k < bound) begin
            @(negedge iclk);
            k++;
        end
        check(use_err ? "err_timeout" : "done_timeout",
              (use_err ? err_cycs.size() : done_cycs.size()) > n0, 1);
    endtask

    initial begin
        int unsigned acc, a2, a3, r0, d0, e0, b0, k1, rises1, bad1, dk1;
        logic p1;
        tif.tx_valid  = 1'b0;
        tif.tx_data   = '0;
        tif.tx_last   = 1'b0;
        tif1.tx_valid = 1'b0;
        tif1.tx_data  = '0;
        tif1.tx_last  = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge iclk);
        check("rst_sclk", sclk, 0);
        check("rst_sout", serial_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", tif.tx_ready, 0);
        rstn = 1'b1;
        @(negedge iclk);
        check("ready_after_rst", tif.tx_ready, 1);
        repeat (2) @(negedge iclk);

        // Single byte 0xA5
        r0 = rise_cycs.size(); d0 = done_cycs.size(); e0 = err_cycs.size(); b0 = busy_up.size();
        send(8'hA5, 1'b1, 1'b1, acc);
        tif.tx_valid = 1'b0;
        wait_ev(1'b0, d0, 100);
        check("t1_gap_sclk", sclk, 0);
        check("t1_gap_sout", serial_out, 0);
        check("t1_done_ready", tif.tx_ready, 0);
        @(negedge iclk);
        check("t1_ready", tif.tx_ready, 1);
        check("t1_busy", busy, 0);
        check("t1_done_pulse", done, 0);
        check("t1_rises", rise_cycs.size() - r0, 8);
        check("t1_first_rise", rel(rise_cycs, r0, acc), 3);
        check("t1_last_rise", rel(rise_cycs, r0 + 7, acc), 31);
        check("t1_done_cyc", rel(done_cycs, d0, acc), 49);
        check("t1_busy_up", rel(busy_up, b0, acc), 1);
        check("t1_busy_dn", rel(busy_dn, b0, acc), 50);
        check("t1_no_err", err_cycs.size(), e0);
        check("t1_left", exp_bits.size(), 0);
        check("t1_rx_ptr", rx_ptr, 8'hA5);

        // Back-to-back stream 0x03, 0x11, 0x22
        repeat (4) @(negedge iclk);
        r0 = rise_cycs.size(); d0 = done_cycs.size(); e0 = err_cycs.size();
        send(8'h03, 1'b0, 1'b1, acc);
        send(8'h11, 1'b0, 1'b1, a2);
        send(8'h22, 1'b1, 1'b1, a3);
        tif.tx_valid = 1'b0;
        wait_ev(1'b0, d0, 150);
        @(negedge iclk);
        check("t2_wait_len", a2 - acc, 33);
        check("t2_rises", rise_cycs.size() - r0, 24);
        check("t2_low_b01", rel(rise_cycs, r0 + 8, 0) - rel(rise_cycs, r0 + 7, 0) - 2, 3);
        check("t2_low_b12", rel(rise_cycs, r0 + 16, 0) - rel(rise_cycs, r0 + 15, 0) - 2, 3);
        check("t2_done_cnt", done_cycs.size() - d0, 1);
        check("t2_done_cyc", rel(done_cycs, d0, a3), 49);
        check("t2_no_err", err_cycs.size(), e0);
        check("t2_rx_ptr", rx_ptr, 8'h05);
        check("t2_rx_wdata", rx_wdata, 8'h22);
        check("t2_left", exp_bits.size(), 0);

        // Underrun after 0x04, 0x10
        repeat (4) @(negedge iclk);
        r0 = rise_cycs.size(); d0 = done_cycs.size(); e0 = err_cycs.size();
        send(8'h04, 1'b0, 1'b1, acc);
        send(8'h10, 1'b0, 1'b1, a2);
        tif.tx_valid = 1'b0;
        wait_ev(1'b1, e0, 120);
        check("t3_err_busy", busy, 1);
        @(negedge iclk);
        check("t3_err_cyc", rel(err_cycs, e0, a2), 49);
        check("t3_err_pulse", err, 0);
        check("t3_ready", tif.tx_ready, 1);
        check("t3_busy", busy, 0);
        check("t3_no_done", done_cycs.size(), d0);
        check("t3_rises", rise_cycs.size() - r0, 16);
        check("t3_left", exp_bits.size(), 0);

        // Reset during bit 4 of 0x5A, then a fresh transaction
        repeat (12) @(negedge iclk);
        r0 = rise_cycs.size(); d0 = done_cycs.size(); e0 = err_cycs.size();
        send(8'h5A, 1'b1, 1'b1, acc);
        tif.tx_valid = 1'b0;
        repeat (13) @(negedge iclk);
        rstn = 1'b0;
        @(negedge iclk);
        check("t4_rises_before", rise_cycs.size() - r0, 3);
        check("t4_sclk", sclk, 0);
        check("t4_sout", serial_out, 0);
        check("t4_busy", busy, 0);
        check("t4_ready", tif.tx_ready, 0);
        rstn = 1'b1;
        exp_bits.delete();
        @(negedge iclk);
        check("t4_ready_after", tif.tx_ready, 1);
        repeat (7) @(negedge iclk);
        r0 = rise_cycs.size();
        send(8'hC3, 1'b1, 1'b1, acc);
        tif.tx_valid = 1'b0;
        wait_ev(1'b0, d0, 100);
        @(negedge iclk);
        check("t4_rises", rise_cycs.size() - r0, 8);
        check("t4_done_cnt", done_cycs.size() - d0, 1);
        check("t4_done_cyc", rel(done_cycs, d0, acc), 49);
        check("t4_no_err", err_cycs.size(), e0);
        check("t4_rx_ptr", rx_ptr, 8'hC3);
        check("t4_left", exp_bits.size(), 0);

        // First byte 0x00 followed by 0x07
        repeat (12) @(negedge iclk);
        r0 = rise_cycs.size(); d0 = done_cycs.size(); e0 = err_cycs.size();
`ifdef PICO_TX_ADDR_CHECK_EN
        send(8'h00, 1'b0, 1'b0, acc);
        send(8'h07, 1'b1, 1'b1, a2);
        tif.tx_valid = 1'b0;
        wait_ev(1'b0, d0, 100);
        @(negedge iclk);
        check("t5_err_cyc", rel(err_cycs, e0, acc), 1);
        check("t5_reaccept", a2 - acc, 1);
        check("t5_first_rise", rel(rise_cycs, r0, a2), 3);
        check("t5_rises", rise_cycs.size() - r0, 8);
        check("t5_rx_ptr", rx_ptr, 8'h07);
`else
        send(8'h00, 1'b0, 1'b1, acc);
        send(8'h07, 1'b1, 1'b1, a2);
        tif.tx_valid = 1'b0;
        wait_ev(1'b0, d0, 150);
        @(negedge iclk);
        check("t5_no_err", err_cycs.size(), e0);
        check("t5_rises", rise_cycs.size() - r0, 16);
        check("t5_rx_wdata", rx_wdata, 8'h07);
`endif
        check("t5_done_cnt", done_cycs.size() - d0, 1);
        check("t5_left", exp_bits.size(), 0);

        // CLK_DIV = 1 instance, byte 0xFF last
        tif1.tx_data  = 8'hFF;
        tif1.tx_last  = 1'b1;
        tif1.tx_valid = 1'b1;
        k1 = 0;
        while (!tif1.tx_ready && k1 < 50) begin
            @(negedge iclk);
            k1++;
        end
        check("t6_ready_wait", tif1.tx_ready, 1);
        @(negedge iclk);
        tif1.tx_valid = 1'b0;
        rises1 = 0; bad1 = 0; dk1 = 0; p1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (sclk1 && !p1) begin
                rises1++;
                if (k != 2 * rises1 || !sout1) bad1++;
            end
            if (done1) dk1 = k;
            p1 = sclk1;
            @(negedge iclk);
        end
        check("t6_rises", rises1, 8);
        check("t6_rise_pattern", bad1, 0);
        check("t6_done_cyc", dk1, 33);
        check("t6_busy_end", busy1, 0);
        check("t6_err", err1, 0);

        check("extra_rises", extra_rises, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pico_tx_controller.md
# pico_tx_controller

Controller-side serial transmitter for the PICO link. It takes bytes from a valid/ready stream and drives `sclk` and `serial_out` into the chip's PICO receiver. The first byte of a transaction is the register address; each following byte is write data, and the receiver auto-increments the address. The block frames each transaction by holding `sclk` idle long enough for the receiver's clock comparator to reset its framing. It sits in the FPGA/test-controller side of the design and is also instantiated in the PICO testbench as the stimulus source.

## Interface
Parameters:
- `CLK_DIV`, default 2: `iclk` cycles per `sclk` half-period; must be ≥1.
- `GAP_CYCLES`, default 16: `iclk` cycles of `sclk` low that close a transaction; must be ≥8.

Ports:
- `iclk`, input, 1: the block's only clock; every flop uses its rising edge.
- `rstn`, input, 1: synchronous, active-low reset.
- `tx_data`, input, 8: byte to send, MSB first.
- `tx_valid`, input, 1: `tx_data` and `tx_last` are valid.
- `tx_last`, input, 1: this byte ends the transaction.
- `tx_ready`, output, 1: the block accepts a byte this cycle. Decoded from state only; no combinational path from inputs.
- `sclk`, output, 1: serial clock to the receiver. Registered.
- `serial_out`, output, 1: serial data to the receiver. Registered.
- `busy`, output, 1: a transaction is in progress.
- `done`, output, 1: one-cycle pulse when a transaction completes normally.
- `err`, output, 1: one-cycle pulse on underrun, or on a rejected address when the check is compiled in.

## Operation
- States: IDLE, SHIFT, WAIT, GAP.
- Acceptance: `tx_valid & tx_ready` at a rising edge of `iclk`. `tx_ready` = 1 in IDLE and WAIT, 0 otherwise.
- IDLE → SHIFT on acceptance. The byte is loaded into an 8-bit shift register. `last_q` ← `tx_last`.
- SHIFT sends 8 bits, MSB first. Each bit is a low phase then a high phase:
  - Low phase: CLK_DIV cycles with `sclk` = 0 and `serial_out` = the current bit.
  - High phase: CLK_DIV cycles with `sclk` = 1.
  - `serial_out` changes only while `sclk` is low. The receiver samples on the `sclk` rising edge.
- After bit 0's high phase: go to GAP if `last_q` = 1, else go to WAIT.
- WAIT:
  - `sclk` = 0 and `serial_out` holds its last value.
  - An acceptance returns to SHIFT with the new byte.
  - A stall counter counts cycles in WAIT. If GAP_CYCLES cycles pass with no acceptance: pulse `err`, go to IDLE, and do not pulse `done`. The receiver has already reset its framing, so the transaction is dead.
- GAP:
  - `sclk` = 0 and `serial_out` = 0 for GAP_CYCLES cycles.
  - Then pulse `done` for one cycle and go to IDLE.
- `busy` = 1 from the cycle after the first acceptance through the `done` or `err` cycle inclusive.
- Single-byte transaction (`tx_last` on the first byte): legal. The receiver only loads its address pointer.
- `tx_last` on a WAIT-accepted byte ends the transaction after that byte.
- Inputs presented while `tx_ready` = 0 are ignored.
- Reset, including mid-operation:
  - Next edge: state = IDLE.
  - `sclk` = 0, `serial_out` = 0, `busy` = 0, `done` = 0, `err` = 0, `tx_ready` = 0.
  - `tx_ready` = 1 from the first cycle after `rstn` returns to 1.
  - The receiver sees an idle `sclk` and reframes on its own. No `done` or `err` is issued for the aborted transaction.
- Counters:
  - The half-period counter is wide enough for CLK_DIV−1.
  - The bit counter is 3 bits and wraps 7→0 at the end of a byte.
  - The gap/stall counter is wide enough for GAP_CYCLES.

## Timing
- Call the acceptance edge cycle 0.
- Bit 7 appears on `serial_out` in cycle 1.
- A byte occupies cycles 1 … 16·CLK_DIV.
- First `sclk` rise: cycle 1+CLK_DIV. Rise k (k = 0…7): cycle 1+CLK_DIV+2k·CLK_DIV.
- Back-to-back bytes (`tx_valid` held high): WAIT lasts exactly one cycle. Between bytes, `sclk` low lasts CLK_DIV+1 cycles.
- Last byte:
  - GAP spans cycles 16·CLK_DIV+1 … 16·CLK_DIV+GAP_CYCLES.
  - `done` pulses in cycle 16·CLK_DIV+GAP_CYCLES+1.
  - `tx_ready` = 1 from the cycle after that.
- Underrun: `err` pulses in the cycle after the GAP_CYCLES-th cycle spent in WAIT.

## Configuration
- `PICO_TX_ADDR_CHECK_EN`:
  - Defined: a first byte of 0x00 in IDLE is accepted but not sent. `err` pulses in cycle 1, state stays IDLE, and `sclk` never toggles. This matters because the receiver treats pointer 0 as unset, so the next byte would be misread as an address. Data bytes of 0x00 are sent normally.
  - Undefined: every byte is sent as-is, and `err` comes only from underrun.

## Test plan
All scenarios use CLK_DIV = 2 and GAP_CYCLES = 16 unless stated.
- Single byte 0xA5, `tx_last` = 1: `serial_out` sampled at 8 `sclk` rises = 1,0,1,0,0,1,0,1. First rise in cycle 3. `done` in cycle 49. `busy` high cycles 1–49.
- Stream 0x03, 0x11, 0x22 (last) with `tx_valid` held high: 24 rises, inter-byte `sclk` low = 3 cycles, one `done`, no `err`. The receiver model ends with pointer 0x05 and write data 0x22.
- Stream 0x04, 0x10, then `tx_valid` low for 20 cycles: `err` in the 17th cycle after entering WAIT, no `done`, state IDLE, `tx_ready` = 1.
- `rstn` low for 1 cycle during bit 4 of byte 0x5A: next cycle `sclk` = 0, `serial_out` = 0, `busy` = 0. A fresh transaction starting 8 cycles later completes with correct bits.
- First byte 0x00, then 0x07: with `PICO_TX_ADDR_CHECK_EN`, `err` in cycle 1, no `sclk` edges, and 0x07 is sent as an address. Without the macro, 16 rises are sent.
- CLK_DIV = 1, byte 0xFF last: rises every 2 cycles, `done` in cycle 33.
